// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
// Buffered 8N1 UART transmitter. Bytes arrive over a valid/ready handshake,
// are queued in a small FIFO and are then sent on o_tx. Queued bytes are
// sent back to back, so nothing is lost while a frame is on the line.
//
// Ports
//   clk           system clock
//   i_reset       synchronous, active-high reset; aborts any frame in progress
//   i_data[0:7]   byte to send (i_data[0] is the MSB, i_data[7] is the LSB)
//   i_valid       i_data is valid this cycle
//   o_ready       FIFO can accept a byte this cycle
//   o_tx          serial line, idle high, LSB first
//   o_busy        a frame is in progress
//   o_fifo_count  bytes queued, not counting the byte currently being sent
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int CW           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic [0:7]    i_data,
  input  logic          i_valid,
  output logic          o_ready,
  output logic          o_tx,
  output logic          o_busy,
  output logic [CW-1:0] o_fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [7:0]    r_shift;
  logic [TW-1:0] r_bit_timer;
  logic [2:0]    r_bit_idx;

  logic w_push;
  logic w_pop;
  logic w_timer_done;
  logic w_last_bit;
  logic w_fifo_nonempty;

  assign w_fifo_nonempty = (r_count != '0);
  assign w_timer_done    = (r_bit_timer == TIMER_LAST);
  assign w_last_bit      = (r_bit_idx == 3'd7);

  // A full FIFO refuses a push even when a pop happens on the same edge.
  assign o_ready = (r_count != COUNT_FULL);
  assign w_push  = i_valid && o_ready;

  // Next-state logic. A pop happens either from IDLE or in the final STOP
  // cycle; popping in STOP chains straight into the next START bit with
  // no idle gap on the line.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_nonempty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_timer_done) begin
          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_timer_done && w_last_bit) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_timer_done) begin
          if (w_fifo_nonempty) begin
            w_pop        = 1'b1;
            w_next_state = S_START;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Bit timer and bit index. Both restart from zero whenever the state
  // changes; inside DATA the index advances at the end of each bit.
  always_ff @(posedge clk) begin
    if (i_reset || (w_next_state != r_state)) begin
      r_bit_timer <= '0;
      r_bit_idx   <= '0;
    end else if (r_state == S_IDLE) begin
      r_bit_timer <= '0;
      r_bit_idx   <= '0;
    end else if (w_timer_done) begin
      r_bit_timer <= '0;
      if (r_state == S_DATA) begin
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end else begin
      r_bit_timer <= r_bit_timer + 1'b1;
    end
  end

  // Shift register. The head byte is loaded on a pop and shifted right
  // after each data bit, so bit 0 is always the bit on the line.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_shift <= '0;
    end else if (w_pop) begin
      r_shift <= r_mem[r_rd_ptr];
    end else if ((r_state == S_DATA) && w_timer_done) begin
      r_shift <= {1'b0, r_shift[7:1]};
    end
  end

  // FIFO storage. It needs no reset because the pointers and count define
  // which entries are valid. Assigning i_data[0:7] to the [7:0] entry keeps
  // the numeric value, so i_data[7] lands in bit 0 and is sent first.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally because the depth
  // is a power of two.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_tx         = (r_state == S_START) ? 1'b0 :
                        (r_state == S_DATA)  ? r_shift[0] : 1'b1;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
// Self-checking bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A reference model tracks the queue of accepted bytes and the position
// inside the current frame. From those it predicts o_tx, o_busy, o_ready and
// o_fifo_count every cycle. A serial decoder rebuilds bytes from o_tx and
// compares them with the bytes the model started sending.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int FRAME = 10 * CPB;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [0:7]    i_data;
  logic          i_valid;
  logic          o_ready;
  logic          o_tx;
  logic          o_busy;
  logic [CW-1:0] o_fifo_count;

  int checks   = 0;
  int failures = 0;

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_data      (i_data),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_tx        (o_tx),
    .o_busy      (o_busy),
    .o_fifo_count(o_fifo_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model state
  logic [7:0] mQ[$];
  logic [7:0] expFrames[$];
  logic [7:0] decodedLog[$];
  int         mLeft = 0;
  logic [7:0] mByte = '0;
  bit         mPush = 1'b0;
  bit         mPop = 1'b0;
  bit         mLastPush = 1'b0;
  bit         mLastPop = 1'b0;
  bit         checkEn = 1'b0;

  // Decoder state
  bit         decActive = 1'b0;
  int         decCyc = 0;
  logic [7:0] decByte = '0;

  function automatic logic expTx(input int left, input logic [7:0] b);
    int seg;
    if (left == 0) return 1'b1;
    seg = (FRAME - left) / CPB;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  // Model update on each rising edge. A frame lasts FRAME cycles. The next
  // byte starts when the line is idle or the current frame is on its last
  // cycle. A push is judged against the occupancy before any pop.
  always @(posedge clk) begin
    mLastPush = 1'b0;
    mLastPop  = 1'b0;
    if (i_reset) begin
      mQ.delete();
      expFrames.delete();
      mLeft = 0;
    end else begin
      mPop  = (mQ.size() > 0) && (mLeft <= 1);
      mPush = i_valid && (mQ.size() != DEPTH);
      if (mPop) begin
        mByte = mQ.pop_front();
        expFrames.push_back(mByte);
        mLeft = FRAME;
      end else if (mLeft > 0) begin
        mLeft--;
      end
      if (mPush) mQ.push_back(i_data);
      mLastPush = mPush;
      mLastPop  = mPop;
    end
  end

  // Every-cycle comparison against the model, followed by the line decoder.
  // The decoder samples each bit at its middle cycle.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("tx", o_tx, expTx(mLeft, mByte));
      checkOutput("busy", o_busy, mLeft != 0);
      checkOutput("fifo_count", o_fifo_count, mQ.size());
      checkOutput("ready", o_ready, mQ.size() != DEPTH);
      if (i_reset) begin
        decActive = 1'b0;
      end else if (!decActive) begin
        if (o_tx === 1'b0) begin
          decActive = 1'b1;
          decCyc    = 0;
        end
      end else begin
        decCyc++;
        if ((decCyc % CPB == CPB / 2) && (decCyc / CPB >= 1) && (decCyc / CPB <= 8))
          decByte[decCyc/CPB-1] = o_tx;
        if (decCyc == 9 * CPB + CPB / 2) begin
          checkOutput("stop_bit", o_tx, 1);
          if (expFrames.size() > 0) checkOutput("frame_byte", decByte, expFrames.pop_front());
          else checkOutput("frame_pending", expFrames.size(), 1);
          decodedLog.push_back(decByte);
          decActive = 1'b0;
        end
      end
    end
  end

  task automatic applyReset(input int n);
    i_reset = 1'b1;
    i_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    i_reset = 1'b0;
  endtask

  task automatic applyIdle(input int n);
    i_valid = 1'b0;
    i_data  = 8'($urandom);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offers one byte and holds it until the handshake accepts it.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    i_valid = 1'b1;
    i_data  = b;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!mLastPush && waited < 200);
    if (!mLastPush) checkOutput("push_accepted", {31'b0, mLastPush}, 1);
    i_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int w = 0;
    while ((mQ.size() != 0 || mLeft != 0) && w < 3000) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 3000) checkOutput("drain_done", w < 3000, 1);
    applyIdle(4);
    checkOutput("frames_outstanding", expFrames.size(), 0);
  endtask

  initial begin
    int n0;
    int lat;
    int busyCyc;
    int wt;
    i_reset = 1'b1;
    i_valid = 1'b0;
    i_data  = '0;

    // Reset held for three cycles, then idle.
    @(posedge clk);
    #1;
    checkEn = 1'b1;
    applyReset(2);
    checkOutput("reset_tx", o_tx, 1);
    checkOutput("reset_ready", o_ready, 1);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_count", o_fifo_count, 0);
    applyIdle(10);

    // Single byte: latency and frame length.
    n0 = decodedLog.size();
    applyStimulus(8'hA5);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (o_tx !== 1'b0 && lat < 50);
    checkOutput("start_latency", lat, 1);
    busyCyc = 0;
    while (o_busy === 1'b1 && busyCyc < 100) begin
      busyCyc++;
      @(posedge clk);
      #1;
    end
    checkOutput("frame_length", busyCyc, FRAME);
    applyIdle(5);
    checkOutput("single_frames", decodedLog.size() - n0, 1);
    if (decodedLog.size() > n0) checkOutput("single_byte", decodedLog[n0], 8'hA5);

    // Burst of five bytes on consecutive cycles.
    n0 = decodedLog.size();
    for (int b = 1; b <= 5; b++) applyStimulus(8'(b));
    waitDrain();
    checkOutput("burst_frames", decodedLog.size() - n0, 5);
    for (int k = 0; k < 5; k++)
      if (decodedLog.size() > n0 + k) checkOutput("burst_order", decodedLog[n0+k], k + 1);

    // Full FIFO with a simultaneous pop in the last STOP cycle.
    for (int b = 8'h11; b <= 8'h15; b++) applyStimulus(8'(b));
    checkOutput("full_count", o_fifo_count, 4);
    checkOutput("full_ready", o_ready, 0);
    i_valid = 1'b1;
    i_data  = 8'h66;
    wt = 0;
    do begin
      @(posedge clk);
      #1;
      wt++;
    end while (!mLastPop && wt < 100);
    checkOutput("full_pop_refused_count", o_fifo_count, 3);
    checkOutput("full_pop_ready", o_ready, 1);
    @(posedge clk);
    #1;
    checkOutput("full_refill_count", o_fifo_count, 4);
    i_valid = 1'b0;
    waitDrain();

    // Reset in the middle of a data bit, with two bytes queued.
    applyStimulus(8'h3C);
    applyStimulus(8'h77);
    applyStimulus(8'h88);
    applyIdle(8);
    checkOutput("mid_busy", o_busy, 1);
    checkOutput("mid_count", o_fifo_count, 2);
    n0 = decodedLog.size();
    applyReset(1);
    checkOutput("abort_tx", o_tx, 1);
    checkOutput("abort_count", o_fifo_count, 0);
    checkOutput("abort_busy", o_busy, 0);
    applyIdle(100);
    checkOutput("abort_no_frames", decodedLog.size() - n0, 0);

    // Random traffic with random gaps.
    n0 = decodedLog.size();
    for (int i = 0; i < 200; i++) begin
      int gap;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(10, 60) : $urandom_range(0, 3);
      if (gap > 0) applyIdle(gap);
      applyStimulus(8'($urandom_range(0, 255)));
    end
    waitDrain();
    checkOutput("random_frames", decodedLog.size() - n0, 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered 8N1 UART transmitter: bytes are pushed over a valid/ready handshake into a FIFO and serialised on o_tx.
- Sits on the clk_gen clock domain, next to uart_receiver.
- Replaces the bare transmitter wherever bytes can arrive faster than one frame time. Examples are loopback bursts and command-response echo.
- Bytes are never dropped while the line is busy.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal when ≥2.
- FIFO_DEPTH, 8: byte entries in the FIFO. Must be a power of 2 and ≥2.
- CW, $clog2(FIFO_DEPTH)+1: width of the occupancy count. Derived; do not override.

Ports:
- clk  in  1  system clock (clk_gen output)
- i_reset  in  1  synchronous, active-high reset
- i_data  in  [0:7]  byte to send. i_data[0] is the MSB, i_data[7] is the LSB.
- i_valid  in  1  i_data is valid this cycle
- o_ready  out  1  FIFO can accept a byte this cycle
- o_tx  out  1  serial line, idle high
- o_busy  out  1  a frame is in progress (FSM is not IDLE)
- o_fifo_count  out  [CW-1:0]  number of bytes currently queued, excluding the byte in flight

Behaviour:
- One clock. Reset is synchronous and active-high. All outputs are registered or derived directly from registers.
- Reset values: o_tx=1, o_busy=0, o_fifo_count=0, o_ready=1, FSM=IDLE, read and write pointers=0.
- Reset mid-frame aborts the frame: o_tx=1 from the next cycle and the FIFO is flushed. No partial-frame recovery.
- Push: a byte is accepted at the rising edge where i_valid && o_ready. It is visible in o_fifo_count after that edge.
- o_ready = (o_fifo_count != FIFO_DEPTH).
  - A push is refused when the FIFO is full, even if a pop happens on the same edge.
  - i_data is ignored when not accepted.
- Pop: occurs on the edge where FSM=IDLE and count≠0, or in the last STOP cycle with count≠0. The head byte loads into the shift register.
- There is no bypass: a byte pushed at edge N pops no earlier than edge N+1.
- Push and pop on the same edge: count stays unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states, with a bit-timer counting 0..CLKS_PER_BIT-1:
  - IDLE: o_tx=1. On pop, go to START, with o_tx=0 from that edge.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx = the current shift bit, sent LSB first. Wire order is i_data[7], [6], …, [0]. Each bit lasts CLKS_PER_BIT cycles. After the 8th bit, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. At the final cycle, go to START if count≠0 (back-to-back, no idle gap), otherwise go to IDLE.
- o_busy=1 in START, DATA and STOP.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency from an accepted push (FIFO empty, FSM idle) to the o_tx falling edge is 1 cycle after the accept edge.
- The bit-timer and bit index are reset to 0 at every state entry.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset held for 3 cycles, then released → o_tx=1, o_ready=1, o_busy=0, o_fifo_count=0 throughout the 3 reset cycles and 10 idle cycles.
2. Single push 0xA5 → o_tx low 1 cycle after the accept edge. Each of the following holds 4 cycles: start bit, data bits 1,0,1,0,0,1,0,1, stop bit. Then o_busy=0. Total frame is 40 cycles.
3. Burst push 0x01,0x02,0x03,0x04,0x05 on consecutive cycles → first 4 accepted plus the 5th after the first pop frees space.
   - o_ready=0 only while count=4.
   - 5 frames appear with no idle cycle between a stop bit and the next start.
   - Decoded order is 0x01–0x05.
4. Full plus simultaneous pop: FIFO holds 4 bytes and i_valid is asserted on the STOP final cycle → push refused that edge and accepted the next cycle. Count sequence is 4→3→4.
5. Reset asserted mid-DATA of 0x3C with 2 bytes queued → o_tx=1 on the next cycle, count=0, o_busy=0. No further frames appear.
6. Random scoreboard: 200 random bytes with random i_valid gaps → the serial decoder output equals the accepted push sequence. Count is never >4, and o_tx never glitches low in IDLE.
